// File: rtl/cache_ctrl_if.sv
// rtl/cache_ctrl_if.sv - cache command/status bus and word-wide memory port seen by cache_ctrl
interface cache_ctrl_if #(
  parameter int ADDR_BITS = 32,
  parameter int TAG_BITS  = 23
);
  logic [ADDR_BITS-1:0] cache_addr;
  logic                 cache_load;
  logic                 cache_store;
  logic                 cache_replace;
  logic                 cache_invalid;
  logic [2:0]           cache_u_b_h_w;
  logic [31:0]          cache_din;
  logic [31:0]          cache_dout;
  logic                 cache_hit;
  logic                 cache_valid;
  logic                 cache_dirty;
  logic [TAG_BITS-1:0]  cache_tag;

  logic                 mem_cs_o;
  logic                 mem_we_o;
  logic [ADDR_BITS-1:0] mem_addr_o;
  logic [31:0]          mem_data_o;
  logic [31:0]          mem_data_i;
  logic                 mem_ack_i;

  modport master (
    output cache_addr, cache_load, cache_store, cache_replace, cache_invalid,
           cache_u_b_h_w, cache_din,
    input  cache_dout, cache_hit, cache_valid, cache_dirty, cache_tag,
    output mem_cs_o, mem_we_o, mem_addr_o, mem_data_o,
    input  mem_data_i, mem_ack_i
  );

  modport slave (
    input  cache_addr, cache_load, cache_store, cache_replace, cache_invalid,
           cache_u_b_h_w, cache_din,
    output cache_dout, cache_hit, cache_valid, cache_dirty, cache_tag,
    input  mem_cs_o, mem_we_o, mem_addr_o, mem_data_o,
    output mem_data_i, mem_ack_i
  );
endinterface

// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - 2-way L1 cache controller: hit in request cycle, dirty write-back,
// line fill from word-wide memory, then retry of the stalled CPU access.
module cache_ctrl #(
  parameter int ADDR_BITS  = 32,
  parameter int TAG_BITS   = 23,
  parameter int LINE_WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_r,
  input  logic                 en_w,
  input  logic [ADDR_BITS-1:0] addr_rw,
  input  logic [2:0]           u_b_h_w,
  input  logic [31:0]          data_w,
  output logic [31:0]          data_r,
  output logic                 stall,
  cache_ctrl_if.master         bus,
  output logic [31:0]          hit_cnt,
  output logic [31:0]          miss_cnt
);

  localparam logic [1:0] LAST_WORD = 2'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BACK = 2'd1,
    S_FILL = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [1:0]          wcnt, wcnt_nxt;
  logic [TAG_BITS-1:0] vtag, vtag_nxt;
  logic                retry;
  logic                hit_inc, miss_inc;

  logic                 req;
  logic [4:0]           idx;
  logic [ADDR_BITS-1:0] victim_addr;
  logic [ADDR_BITS-1:0] fill_addr;

  assign req         = en_r | en_w;
  assign idx         = addr_rw[8:4];
  assign victim_addr = {vtag, idx, wcnt, 2'b00};
  assign fill_addr   = {addr_rw[31:4], wcnt, 2'b00};
  assign data_r      = bus.cache_dout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      wcnt     <= 2'd0;
      vtag     <= '0;
      retry    <= 1'b0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      vtag  <= vtag_nxt;
      // The access replayed right after a fill hits by construction; it is not a new hit.
      retry <= (state == S_WAIT);
      if (hit_inc && (hit_cnt != 32'hFFFF_FFFF))
        hit_cnt <= hit_cnt + 32'd1;
      if (miss_inc && (miss_cnt != 32'hFFFF_FFFF))
        miss_cnt <= miss_cnt + 32'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    vtag_nxt  = vtag;
    stall     = 1'b0;
    hit_inc   = 1'b0;
    miss_inc  = 1'b0;

    bus.cache_addr    = '0;
    bus.cache_load    = 1'b0;
    bus.cache_store   = 1'b0;
    bus.cache_replace = 1'b0;
    bus.cache_invalid = 1'b0;
    bus.cache_u_b_h_w = 3'b000;
    bus.cache_din     = '0;

    bus.mem_cs_o   = 1'b0;
    bus.mem_we_o   = 1'b0;
    bus.mem_addr_o = '0;
    bus.mem_data_o = '0;

    case (state)
      S_IDLE: begin
        bus.cache_addr    = addr_rw;
        bus.cache_load    = en_r & ~en_w;
        bus.cache_store   = en_w & bus.cache_hit;
        bus.cache_din     = data_w;
        bus.cache_u_b_h_w = u_b_h_w;
        if (req) begin
          if (bus.cache_hit) begin
            hit_inc = ~retry;
          end else begin
            stall    = 1'b1;
            miss_inc = 1'b1;
            wcnt_nxt = 2'd0;
            if (bus.cache_valid && bus.cache_dirty) begin
              vtag_nxt  = bus.cache_tag;
              state_nxt = S_BACK;
            end else begin
              state_nxt = S_FILL;
            end
          end
        end
      end

      S_BACK: begin
        stall          = 1'b1;
        // No command is issued, so cache_dout presents the victim word at victim_addr.
        bus.cache_addr = victim_addr;
        bus.mem_cs_o   = 1'b1;
        bus.mem_we_o   = 1'b1;
        bus.mem_addr_o = victim_addr;
        bus.mem_data_o = bus.cache_dout;
        if (bus.mem_ack_i) begin
          wcnt_nxt = wcnt + 2'd1;
          if (wcnt == LAST_WORD)
            state_nxt = S_FILL;
        end
      end

      S_FILL: begin
        stall          = 1'b1;
        bus.cache_addr = fill_addr;
        bus.mem_cs_o   = 1'b1;
        bus.mem_addr_o = fill_addr;
        if (bus.mem_ack_i) begin
          bus.cache_replace = 1'b1;
          bus.cache_din     = bus.mem_data_i;
          bus.cache_u_b_h_w = 3'b010;
          wcnt_nxt          = wcnt + 2'd1;
          if (wcnt == LAST_WORD)
            state_nxt = S_WAIT;
        end
      end

      S_WAIT: begin
        stall     = 1'b1;
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// tb/tb_cache_ctrl.sv - scoreboard bench for cache_ctrl with behavioral 2-way cache and
// variable-latency word memory.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_r, en_w;
  logic [31:0] addr_rw, data_w, data_r;
  logic [2:0]  u_b_h_w;
  logic        stall;
  logic [31:0] hit_cnt, miss_cnt;

  always #5 clk = ~clk;

  cache_ctrl_if bus ();

  cache_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .en_r     (en_r),
    .en_w     (en_w),
    .addr_rw  (addr_rw),
    .u_b_h_w  (u_b_h_w),
    .data_w   (data_w),
    .data_r   (data_r),
    .stall    (stall),
    .bus      (bus.master),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory image and the CPU-visible reference image
  logic [31:0] mem     [0:4095];
  logic [31:0] ref_mem [0:4095];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } mem_op_t;

  mem_op_t     exp_mem[$];
  logic [31:0] exp_rd[$];

  // Behavioral 2-way cache, 32 sets, 4-word lines
  logic [22:0] c_tag [2][32];
  logic        c_vld [2][32];
  logic        c_drt [2][32];
  logic        c_lru [32];
  logic [31:0] c_dat [2][32][4];

  logic [4:0]  m_idx;
  logic [22:0] m_tag;
  logic [1:0]  m_w;
  logic        m_h0, m_h1, m_way;

  always_comb begin
    m_idx = bus.cache_addr[8:4];
    m_tag = bus.cache_addr[31:9];
    m_w   = bus.cache_addr[3:2];
    m_h0  = c_vld[0][m_idx] && (c_tag[0][m_idx] == m_tag);
    m_h1  = c_vld[1][m_idx] && (c_tag[1][m_idx] == m_tag);
    m_way = (m_h0 || m_h1) ? m_h1 : c_lru[m_idx];
    bus.cache_hit   = m_h0 | m_h1;
    bus.cache_tag   = c_tag[m_way][m_idx];
    bus.cache_valid = c_vld[m_way][m_idx];
    bus.cache_dirty = c_drt[m_way][m_idx];
    bus.cache_dout  = c_dat[m_way][m_idx][m_w];
  end

  always @(posedge clk) begin
    if (bus.cache_store && bus.cache_hit) begin
      c_dat[m_way][m_idx][m_w] <= bus.cache_din;
      c_drt[m_way][m_idx]      <= 1'b1;
      c_lru[m_idx]             <= ~m_way;
    end else if (bus.cache_load && bus.cache_hit) begin
      c_lru[m_idx] <= ~m_way;
    end else if (bus.cache_replace) begin
      c_tag[m_way][m_idx]      <= m_tag;
      c_vld[m_way][m_idx]      <= 1'b1;
      c_drt[m_way][m_idx]      <= 1'b0;
      c_dat[m_way][m_idx][m_w] <= bus.cache_din;
      c_lru[m_idx]             <= ~m_way;
    end
  end

  // Memory responder: ack after ack_dly wait cycles per word, checks each transfer
  int          ack_dly = 0;
  int          wc = 0;
  int          stab_err = 0;
  int          rep_cnt = 0;
  logic        prev_cs = 1'b0;
  logic [31:0] prev_addr, prev_data;

  always @(negedge clk) begin
    mem_op_t     e;
    logic [31:0] a;
    if (prev_cs && (bus.mem_cs_o === 1'b1) && (bus.mem_ack_i !== 1'b1)) begin
      if ((bus.mem_addr_o !== prev_addr) || (bus.mem_we_o && (bus.mem_data_o !== prev_data)))
        stab_err++;
    end
    prev_cs   = (bus.mem_cs_o === 1'b1);
    prev_addr = bus.mem_addr_o;
    prev_data = bus.mem_data_o;

    if (bus.mem_cs_o !== 1'b1) begin
      bus.mem_ack_i = 1'b0;
      wc = 0;
    end else begin
      if (bus.mem_ack_i) wc = 0;
      if (wc == ack_dly) begin
        bus.mem_ack_i = 1'b1;
        a = bus.mem_addr_o;
        if (exp_mem.size() == 0) begin
          check_eq("mem_extra_op", 32'(exp_mem.size()), 32'd1);
        end else begin
          e = exp_mem.pop_front();
          check_eq("mem_we", {31'd0, bus.mem_we_o}, {31'd0, e.we});
          check_eq("mem_addr", a, e.addr);
          if (e.we) check_eq("mem_wdata", bus.mem_data_o, e.data);
        end
        if (bus.mem_we_o) mem[a[13:2]] = bus.mem_data_o;
        else              bus.mem_data_i = mem[a[13:2]];
      end else begin
        bus.mem_ack_i = 1'b0;
        wc++;
      end
    end
  end

  always begin
    @(negedge clk);
    #1;
    if (bus.cache_replace === 1'b1) rep_cnt++;
  end

  task automatic push_fill(input logic [31:0] a);
    for (int k = 0; k < 4; k++)
      exp_mem.push_back('{1'b0, {a[31:4], 2'(k), 2'b00}, 32'h0});
  endtask

  task automatic push_wb(input logic [31:0] a);
    logic [31:0] wa;
    for (int k = 0; k < 4; k++) begin
      wa = {a[31:4], 2'(k), 2'b00};
      exp_mem.push_back('{1'b1, wa, ref_mem[wa[13:2]]});
    end
  endtask

  task automatic access(input logic wr, input logic rd, input logic [31:0] a,
                        input logic [31:0] d, input int exp_st, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    en_r = rd; en_w = wr; addr_rw = a; data_w = d; u_b_h_w = 3'b010;
    if (rd && !wr) exp_rd.push_back(ref_mem[a[13:2]]);
    if (wr) ref_mem[a[13:2]] = d;
    #1;
    while ((stall === 1'b1) && (n < 400)) begin
      n++;
      @(negedge clk);
      #1;
    end
    check_eq({tag, "_stalls"}, 32'(n), 32'(exp_st));
    if (rd && !wr) check_eq({tag, "_data"}, data_r, exp_rd.pop_front());
    check_eq({tag, "_store_cmd"}, {31'd0, bus.cache_store}, {31'd0, wr});
    check_eq({tag, "_load_cmd"}, {31'd0, bus.cache_load}, {31'd0, rd & ~wr});
    @(posedge clk);
    #1;
    en_r = 1'b0; en_w = 1'b0;
  endtask

  initial begin
    int acks, n;
    rst = 1'b1; en_r = 1'b0; en_w = 1'b0; addr_rw = '0; data_w = '0; u_b_h_w = 3'b000;
    bus.mem_ack_i = 1'b0; bus.mem_data_i = '0;
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = 32'hA500_0000 ^ 32'(i * 4);
      ref_mem[i] = 32'hA500_0000 ^ 32'(i * 4);
    end
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < 32; s++) begin
        c_tag[w][s] = '0; c_vld[w][s] = 1'b0; c_drt[w][s] = 1'b0; c_lru[s] = 1'b0;
        for (int k = 0; k < 4; k++) c_dat[w][s][k] = '0;
      end

    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_stall", {31'd0, stall}, 32'd0);
    check_eq("rst_cs", {31'd0, bus.mem_cs_o}, 32'd0);
    check_eq("rst_mem_addr", bus.mem_addr_o, 32'd0);
    check_eq("rst_hit_cnt", hit_cnt, 32'd0);
    check_eq("rst_miss_cnt", miss_cnt, 32'd0);
    rst = 1'b0;

    push_fill(32'h10);
    access(1'b0, 1'b1, 32'h10, 32'h0, 6, "cold_load");
    check_eq("cold_miss_cnt", miss_cnt, 32'd1);
    check_eq("cold_hit_cnt", hit_cnt, 32'd0);

    access(1'b0, 1'b1, 32'h14, 32'h0, 0, "hit_load");
    check_eq("hit_cnt_1", hit_cnt, 32'd1);

    access(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 0, "store_hit");
    check_eq("hit_cnt_2", hit_cnt, 32'd2);

    push_fill(32'h210);
    access(1'b0, 1'b1, 32'h210, 32'h0, 6, "clean_miss");

    push_wb(32'h10);
    push_fill(32'h410);
    access(1'b0, 1'b1, 32'h410, 32'h0, 10, "dirty_miss");
    check_eq("miss_cnt_3", miss_cnt, 32'd3);
    check_eq("wb_first_word", mem[4], 32'hDEADBEEF);

    push_fill(32'h10);
    access(1'b0, 1'b1, 32'h10, 32'h0, 6, "reload_wb");

    ack_dly = 3; rep_cnt = 0; stab_err = 0;
    push_fill(32'h810);
    access(1'b0, 1'b1, 32'h810, 32'h0, 18, "slow_fill");
    check_eq("slow_replace_cnt", 32'(rep_cnt), 32'd4);
    check_eq("slow_stable", 32'(stab_err), 32'd0);
    ack_dly = 0;

    access(1'b1, 1'b1, 32'h818, 32'h12345678, 0, "rw_both");
    access(1'b0, 1'b1, 32'h818, 32'h0, 0, "rw_readback");
    check_eq("hit_cnt_4", hit_cnt, 32'd4);
    check_eq("miss_cnt_5", miss_cnt, 32'd5);

    exp_mem.push_back('{1'b0, 32'hC10, 32'h0});
    exp_mem.push_back('{1'b0, 32'hC14, 32'h0});
    @(negedge clk);
    en_r = 1'b1; addr_rw = 32'hC10; u_b_h_w = 3'b010;
    acks = 0; n = 0;
    while ((acks < 2) && (n < 50)) begin
      @(negedge clk);
      #1;
      n++;
      if (bus.mem_ack_i === 1'b1) acks++;
    end
    check_eq("rst_fill_acks", 32'(acks), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    en_r = 1'b0;
    #1;
    check_eq("midrst_cs", {31'd0, bus.mem_cs_o}, 32'd0);
    check_eq("midrst_stall", {31'd0, stall}, 32'd0);
    check_eq("midrst_hit_cnt", hit_cnt, 32'd0);
    check_eq("midrst_miss_cnt", miss_cnt, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("exp_mem_left", 32'(exp_mem.size()), 32'd0);
    check_eq("exp_rd_left", 32'(exp_rd.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Controller FSM that drives the 2-way set-associative L1 cache (23-bit tag, 5-bit set index, 4-word lines) on behalf of the CPU data port and the word-wide memory port. It resolves hits in the request cycle. On a miss it stalls the CPU, writes back a dirty LRU victim word by word, fills the line from memory, and then retries the access. It is the initiator for the cache's load/store/replace/invalid command interface and for the memory request/ack handshake.

## Interface
- ADDR_BITS, 32, byte address width
- TAG_BITS, 23, tag width (address bits 31:9)
- LINE_WORDS, 4, words per line (address bits 3:2)

- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- en_r  in  1  CPU load request
- en_w  in  1  CPU store request; wins if en_r is also high
- addr_rw  in  32  CPU byte address; held stable while stall=1
- u_b_h_w  in  3  access width/sign code, passed to the cache on CPU accesses
- data_w  in  32  CPU store data
- data_r  out  32  CPU load data; equals cache_dout
- stall  out  1  high while a request is outstanding and not yet served
- cache_addr  out  32  address to the cache
- cache_load, cache_store, cache_replace, cache_invalid  out  1 each  cache commands
- cache_u_b_h_w  out  3  width code to the cache
- cache_din  out  32  write/fill data to the cache
- cache_dout  in  32  cache read data
- cache_hit, cache_valid, cache_dirty  in  1 each  cache status for the current address
- cache_tag  in  23  tag of the hit way, else tag of the LRU victim
- mem_cs_o  out  1  memory request
- mem_we_o  out  1  1 = write, 0 = read
- mem_addr_o  out  32  word-aligned memory address
- mem_data_o  out  32  write-back data
- mem_data_i  in  32  fill data, valid when mem_ack_i=1
- mem_ack_i  in  1  one-cycle pulse completing the current word
- hit_cnt, miss_cnt  out  32 each  saturating statistics counters

## Operation
- States: S_IDLE, S_BACK, S_FILL, S_WAIT. Word counter is 2 bits (wcnt).
- Definitions used below:
  - req = en_r | en_w
  - idx = addr_rw[8:4]
  - victim address V(k) = {cache_tag, idx, k, 2'b00}
  - fill address F(k) = {addr_rw[31:4], k, 2'b00}
- S_IDLE:
  - cache_addr = addr_rw; cache_load = en_r & ~en_w; cache_store = en_w & cache_hit; cache_din = data_w; cache_u_b_h_w = u_b_h_w.
  - req & cache_hit: stall = 0, access completes this cycle; hit_cnt += 1.
  - req & ~cache_hit: stall = 1; miss_cnt += 1.
    - If cache_valid & cache_dirty: latch victim tag, go to S_BACK.
    - Otherwise go to S_FILL.
    - wcnt is cleared to 0 in either case.
  - ~req: stall = 0, no cache command, no memory request.
- S_BACK:
  - cache_addr = V(wcnt) using the latched victim tag; all cache commands 0, so cache_dout returns the victim word.
  - mem_cs_o = 1, mem_we_o = 1, mem_addr_o = V(wcnt), mem_data_o = cache_dout.
  - On mem_ack_i: wcnt += 1. On the ack for wcnt = 3: wcnt wraps to 0, go to S_FILL.
- S_FILL:
  - mem_cs_o = 1, mem_we_o = 0, mem_addr_o = F(wcnt).
  - On mem_ack_i: cache_addr = F(wcnt), cache_replace = 1, cache_din = mem_data_i, cache_u_b_h_w = 3'b010; wcnt += 1.
  - On the ack for wcnt = 3: go to S_WAIT.
- S_WAIT: one bubble cycle, stall = 1, no commands; go to S_IDLE. The retried access then hits, and hit_cnt is not incremented for it.
- stall = 1 in every non-IDLE state.
- cache_invalid is tied to 0 (reserved).
- Counters saturate at 32'hFFFF_FFFF.
- Outside S_BACK/S_FILL: mem_cs_o = 0, mem_we_o = 0, mem_addr_o = 0, mem_data_o = 0.

## Timing
- Reset: state = S_IDLE, wcnt = 0, victim tag = 0, hit_cnt = 0, miss_cnt = 0. Outputs are then combinational from S_IDLE.
- Hit latency: 0 cycles. Load data is valid in the request cycle; a store is written at the next edge.
- Miss latency: 1 (detect) + 4 write-back acks if dirty + 4 fill acks + 1 (S_WAIT), then the hit cycle.
  - Clean miss with 1-cycle ack: 1 + 4 + 1 = 6 stall cycles.
  - Dirty miss with 1-cycle ack: 10 stall cycles.
- Memory handshake:
  - mem_cs_o is held with a stable address/data until mem_ack_i.
  - On the cycle after an ack, the request advances to the next word; cs stays high and no idle cycle is inserted between words.
  - mem_ack_i while mem_cs_o = 0 is ignored.
- The CPU must hold en_r/en_w/addr_rw/data_w/u_b_h_w stable while stall = 1.
- rst mid-miss:
  - Returns to S_IDLE next cycle; the memory request drops.
  - A partially filled line stays valid in the cache; system reset flow invalidates the cache.

## Test plan
- Reset, then load 0x0000_0010 with cold cache → 6 stall cycles with ack = 1 cycle; memory reads at 0x10, 0x14, 0x18, 0x1C. Retried load returns mem[0x10]; miss_cnt = 1, hit_cnt = 0.
- Load 0x0000_0014 right after the fill → stall = 0, data_r = mem[0x14]; hit_cnt = 1.
- Store word 0xDEADBEEF to 0x10, then load 0x0000_0210 and 0x0000_0410 (same set) → on the third line: 4 memory writes to 0x10..0x1C, first data 0xDEADBEEF, then 4 reads at 0x410..0x41C.
- Memory ack delayed 3 cycles per word → mem_addr_o and mem_data_o stable across the wait; stall = 1 throughout; exactly 4 cache_replace pulses.
- en_r = en_w = 1 on a hit → treated as store: cache_store = 1, cache_load = 0.
- rst asserted on the second fill ack → next cycle state = S_IDLE, mem_cs_o = 0, stall = 0 with no request, counters = 0.
